sfot_ram_arbiter: RTL

- Two-requester arbiter that shares the single-port SFOT 32K x 8 RAM (synchronous read, 1-cycle latency, read and write mutually exclusive per cycle).
- Requester 0 is the CPU bus; requester 1 is the DMA/loader engine.
- Accepts at most one access per cycle, drives the RAM port from registers and routes read data back to the owning requester with a valid strobe.
- Decodes out-of-range addresses so they never reach the RAM.

---
 rtl/sfot_pkg.sv | 19 +
 rtl/sfot_arb_grant.sv | 52 +++++
 rtl/sfot_ram_arbiter.sv | 125 ++++++++++++
 3 files changed

// File: rtl/sfot_pkg.sv
// sfot_pkg: shared definitions for the SFOT RAM arbiter slice.
//   ADDR_W / DATA_W : RAM port widths.
//   REQ_CPU/REQ_DMA : requester IDs as carried in the pipeline tag.
//   tag_t           : per-access tag that travels alongside the RAM pipeline.
package sfot_pkg;

    localparam int unsigned ADDR_W = 16;
    localparam int unsigned DATA_W = 8;

    localparam logic REQ_CPU = 1'b0;
    localparam logic REQ_DMA = 1'b1;

    typedef struct packed {
        logic owner;    // requester that was granted
        logic is_read;  // access expects a data return
        logic oor;      // address outside the implemented RAM
    } tag_t;

endpackage

// File: rtl/sfot_arb_grant.sv
// sfot_arb_grant: combinational two-way grant logic for the SFOT RAM arbiter.
//
// Build option: SFOT_ARB_ROUND_ROBIN_EN
//   defined   - round-robin; a pointer register remembers which requester is
//               preferred on the next contention (the one not granted last).
//   undefined - fixed priority, CPU (requester 0) always wins; no state.
//
// Ports:
//   clk, rst_n  clock / async active-low reset (round-robin build only)
//   req0, req1  requests from CPU and DMA
//   gnt0, gnt1  one-hot-or-zero grants, never asserted without the request
module sfot_arb_grant
    import sfot_pkg::*;
(
`ifdef SFOT_ARB_ROUND_ROBIN_EN
    input  logic clk,
    input  logic rst_n,
`endif
    input  logic req0,
    input  logic req1,
    output logic gnt0,
    output logic gnt1
);

`ifdef SFOT_ARB_ROUND_ROBIN_EN
    logic ptr_q, ptr_d;  // requester preferred on contention

    always_comb begin
        gnt0  = req0 & (~req1 | (ptr_q == REQ_CPU));
        gnt1  = req1 & (~req0 | (ptr_q == REQ_DMA));
        ptr_d = ptr_q;
        // After any grant, favour the requester that did not win.
        if (gnt0) begin
            ptr_d = REQ_DMA;
        end else if (gnt1) begin
            ptr_d = REQ_CPU;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= REQ_CPU;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    assign gnt0 = req0;
    assign gnt1 = req1 & ~req0;
`endif

endmodule

// File: rtl/sfot_ram_arbiter.sv
// sfot_ram_arbiter: shares the single-port SFOT 32K x 8 RAM (synchronous
// read, 1-cycle latency) between the CPU (requester 0) and DMA (requester 1).
//
// Build option: SFOT_ARB_ROUND_ROBIN_EN selects round-robin arbitration
// (see sfot_arb_grant); default is fixed CPU priority.
//
// Pipeline: grant in cycle C -> stage A registers drive the RAM in C+1 ->
// RAM performs the access at the end of C+1 -> read data returns in C+2.
//
// Ports:
//   clk, rst_n                     clock / async active-low reset
//   reqN, weN, addrN, wdataN       requester N access (held until granted)
//   gntN                           combinational grant
//   rvalidN, rdataN                read return strobe and data (data holds)
//   ram_ena/wea/addra/dina         registered RAM port
//   ram_douta                      RAM read data
module sfot_ram_arbiter
    import sfot_pkg::*;
#(
    parameter int unsigned       RAM_DEPTH = 32768,
    parameter logic [DATA_W-1:0] OOR_DATA  = 8'hFF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              gnt0,
    output logic              rvalid0,
    output logic [DATA_W-1:0] rdata0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt1,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata1,
    output logic              ram_ena,
    output logic              ram_wea,
    output logic [ADDR_W-1:0] ram_addra,
    output logic [DATA_W-1:0] ram_dina,
    input  logic [DATA_W-1:0] ram_douta
);

    sfot_arb_grant u_grant (
`ifdef SFOT_ARB_ROUND_ROBIN_EN
        .clk  (clk),
        .rst_n(rst_n),
`endif
        .req0 (req0),
        .req1 (req1),
        .gnt0 (gnt0),
        .gnt1 (gnt1)
    );

    // Selected access for this cycle.
    logic              any_gnt;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              sel_oor;
    logic              sel_ram;

    always_comb begin
        any_gnt   = gnt0 | gnt1;
        sel_we    = gnt1 ? we1    : we0;
        sel_addr  = gnt1 ? addr1  : addr0;
        sel_wdata = gnt1 ? wdata1 : wdata0;
        sel_oor   = (32'(sel_addr) >= RAM_DEPTH);
        sel_ram   = any_gnt & ~sel_oor;
    end

    // Tag pipeline: stage A lines up with the RAM port, stage B with douta.
    logic              valid_a_q, valid_b_q;
    tag_t              tag_a_q, tag_b_q;
    logic [DATA_W-1:0] rdata0_q, rdata1_q;
    logic [DATA_W-1:0] ret_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ram_ena   <= 1'b0;
            ram_wea   <= 1'b0;
            ram_addra <= '0;
            ram_dina  <= '0;
            valid_a_q <= 1'b0;
            tag_a_q   <= '0;
            valid_b_q <= 1'b0;
            tag_b_q   <= '0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
        end else begin
            // Out-of-range accesses never touch the RAM port.
            ram_ena <= sel_ram;
            ram_wea <= sel_ram & sel_we;
            if (sel_ram) begin
                ram_addra <= sel_addr;
                ram_dina  <= sel_wdata;
            end
            valid_a_q       <= any_gnt;
            tag_a_q.owner   <= gnt1 ? REQ_DMA : REQ_CPU;
            tag_a_q.is_read <= ~sel_we;
            tag_a_q.oor     <= sel_oor;
            valid_b_q       <= valid_a_q;
            tag_b_q         <= tag_a_q;
            if (rvalid0) begin
                rdata0_q <= ret_data;
            end
            if (rvalid1) begin
                rdata1_q <= ret_data;
            end
        end
    end

    // Return mux: data passes through during the valid cycle and is held
    // afterwards until the next return to the same requester.
    always_comb begin
        ret_data = tag_b_q.oor ? OOR_DATA : ram_douta;
        rvalid0  = valid_b_q & tag_b_q.is_read & (tag_b_q.owner == REQ_CPU);
        rvalid1  = valid_b_q & tag_b_q.is_read & (tag_b_q.owner == REQ_DMA);
        rdata0   = rvalid0 ? ret_data : rdata0_q;
        rdata1   = rvalid1 ? ret_data : rdata1_q;
    end

endmodule
